// File: rtl/imm_extend_stage_pkg.sv
// Shared encodings for the immediate-extension stage: field-width selects and extension modes.
package imm_extend_stage_pkg;

    typedef logic [1:0] len_sel_t;

    localparam len_sel_t LEN_1  = 2'd0;
    localparam len_sel_t LEN_5  = 2'd1;
    localparam len_sel_t LEN_8  = 2'd2;
    localparam len_sel_t LEN_11 = 2'd3;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Upstream/downstream handshake bundle for the immediate-extension stage.
interface imm_extend_stage_if
    import imm_extend_stage_pkg::*;
#(
    parameter int unsigned IN_W   = 11,
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    len_sel_t          in_len_sel;
    logic              in_sign;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_imm, in_len_sel, in_sign, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_imm, in_len_sel, in_sign, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/imm_extend_stage_core.sv
// Stateless zero/sign extension of a selectable-width immediate field to DATA_W bits.
module imm_extend_core
    import imm_extend_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IN_W   = 11,
    parameter int unsigned FW0    = 1,
    parameter int unsigned FW1    = 5,
    parameter int unsigned FW2    = 8,
    parameter int unsigned FW3    = 11
) (
    input  logic [IN_W-1:0]   imm,
    input  len_sel_t          len_sel,
    input  logic              sign,
    output logic [DATA_W-1:0] data
);
    int unsigned       w;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] low_mask;
    logic [DATA_W-1:0] fill;
    logic              msb;

    // Mask off bits above the field, then fill them with the field MSB in sign mode.
    always_comb begin
        w = FW3;
        case (len_sel)
            LEN_1:  w = FW0;
            LEN_5:  w = FW1;
            LEN_8:  w = FW2;
            LEN_11: w = FW3;
        endcase
        imm_ext  = DATA_W'(imm);
        low_mask = ~({DATA_W{1'b1}} << w);
        msb      = |(imm_ext & (DATA_W'(1) << (w - 1)));
        fill     = (sign == EXT_SIGN) ? {DATA_W{msb}} : '0;
        data     = (imm_ext & low_mask) | (fill & ~low_mask);
    end
endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a main register plus one skid entry.
module imm_extend_stage
    import imm_extend_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IN_W   = 11,
    parameter int unsigned FW0    = 1,
    parameter int unsigned FW1    = 5,
    parameter int unsigned FW2    = 8,
    parameter int unsigned FW3    = 11
) (
    input  logic               clk,
    input  logic               rst,
    imm_extend_stage_if.slave  bus
);
    logic              main_v, main_v_n;
    logic              skid_v, skid_v_n;
    logic [DATA_W-1:0] main_d, main_d_n;
    logic [DATA_W-1:0] skid_d, skid_d_n;
    logic [DATA_W-1:0] ext_c;
    logic              rdy;
    logic [1:0]        occ;
    logic              accept_c;
    logic              deliver_c;

    imm_extend_core #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W),
        .FW0    (FW0),
        .FW1    (FW1),
        .FW2    (FW2),
        .FW3    (FW3)
    ) u_core (
        .imm     (bus.in_imm),
        .len_sel (bus.in_len_sel),
        .sign    (bus.in_sign),
        .data    (ext_c)
    );

    assign accept_c  = bus.in_valid & rdy;
    assign deliver_c = main_v & bus.out_ready;

    // Next-state of main/skid in priority order: flush, skid refill, direct load, skid load, drain.
    always_comb begin
        main_v_n = main_v;
        main_d_n = main_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (bus.flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (deliver_c && skid_v) begin
            main_v_n = 1'b1;
            main_d_n = skid_d;
            skid_v_n = 1'b0;
        end else if (accept_c && (!main_v || deliver_c)) begin
            main_v_n = 1'b1;
            main_d_n = ext_c;
        end else if (accept_c) begin
            skid_v_n = 1'b1;
            skid_d_n = ext_c;
        end else if (deliver_c) begin
            main_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            main_d <= '0;
            skid_v <= 1'b0;
            skid_d <= '0;
            rdy    <= 1'b1;
            occ    <= 2'd0;
        end else begin
            main_v <= main_v_n;
            main_d <= main_d_n;
            skid_v <= skid_v_n;
            skid_d <= skid_d_n;
            rdy    <= !skid_v_n;
            occ    <= 2'(main_v_n) + 2'(skid_v_n);
        end
    end

    assign bus.out_valid = main_v;
    assign bus.out_data  = main_d;
    assign bus.in_ready  = rdy;
    assign bus.occupancy = occ;
endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
Parametrised successor to the fixed 1-bit zero extender. Registered immediate-extension stage in the decode→execute path. It takes a raw immediate field of selectable width and extends it to DATA_W bits, either zero-extended or sign-extended. A valid/ready handshake with a 2-entry skid buffer provides full throughput, a registered in_ready, stall absorption and flush.

Parameters:
- DATA_W, 16: output width. Constraint: DATA_W >= IN_W.
- IN_W, 11: raw immediate input width. Constraint: IN_W >= max(FW0..FW3).
- FW0, 1: field width for len_sel=0.
- FW1, 5: field width for len_sel=1.
- FW2, 8: field width for len_sel=2.
- FW3, 11: field width for len_sel=3.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- in_valid, in, 1: upstream beat valid.
- in_ready, out, 1: stage can accept a beat. Registered.
- in_imm, in, IN_W: raw immediate, LSB-aligned.
- in_len_sel, in, 2: field-width select (FW0..FW3).
- in_sign, in, 1: 1 = sign-extend, 0 = zero-extend.
- flush, in, 1: synchronous pipeline flush.
- out_valid, out, 1: extended result valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, DATA_W: extended immediate.
- occupancy, out, 2: beats held (0..2).

Behaviour:
- Reset is asynchronous, active-high. All outputs are registered and reset to: out_valid=0, out_data=0, occupancy=0, in_ready=1. Both internal entries are cleared.
- Extension is combinational on input and captured at accept, with k = in_len_sel and W = FWk:
  - bits [W-1:0] = in_imm[W-1:0];
  - bits [DATA_W-1:W] = in_sign ? in_imm[W-1] : 0;
  - in_imm bits above W are ignored.
- Extension results for a 1-bit field: zero mode gives 0/1; sign mode gives 0/all-ones.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- Storage is a main register (out_*) plus one skid entry.
- Per-cycle rules, in priority order:
  1. flush=1: main and skid valids cleared. Any beat accepted in the same cycle is dropped. occupancy becomes 0 and in_ready becomes 1 next cycle.
  2. Deliver and skid valid: main loads the skid contents, skid cleared. No accept is possible, because in_ready=0 while skid is valid.
  3. Accept, and main empty or delivering: main loads the extended input.
  4. Accept, main full and not delivering: skid loads the extended input.
  5. Deliver, no accept, skid empty: main valid cleared. out_data holds its last value.
- in_ready next = !(skid valid next).
- Latency: 1 cycle from accept to out_valid when empty.
- Throughput: 1 beat/cycle while out_ready stays high.
- occupancy = main valid + skid valid. It never exceeds 2, and no beat is lost or duplicated.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Asserting rst mid-transfer discards all held beats immediately, without waiting for a clock edge.
- in_len_sel, in_sign and in_imm are sampled only at accept.

Decomposition:
- Shared package holds:
  - LEN_1=2'd0, LEN_5=2'd1, LEN_8=2'd2, LEN_11=2'd3 localparams;
  - EXT_ZERO=1'b0, EXT_SIGN=1'b1.
- One natural combinational sub-module: imm_extend_core. It takes (imm, len_sel, sign) and produces data, carries the same FW*/DATA_W/IN_W parameters, and contains no state.
- The top module holds the main/skid registers and the handshake logic.

Test Plan:
- Extension check. Reset, then in_imm=11'h7FF with len_sel=0 and sign=0, out_ready=1 → out_data=16'h0001 one cycle later. Repeat with sign=1 → 16'hFFFF.
- Sign rule, len_sel=1 (5-bit field):
  - in_imm=11'h010, sign=1 → 16'hFFF0; with sign=0 → 16'h0010.
  - in_imm=11'h7EF, sign=1 → 16'h000F (upper bits ignored).
- Stall: out_ready=0, send 11'h080 (len 8, sign) then 11'h07F (len 8, sign).
  - Required: occupancy reaches 2; in_ready=0; out_data=16'hFF80 stays stable.
  - Raise out_ready → outputs 16'hFF80 then 16'h007F on consecutive cycles.
- Full throughput: 8 back-to-back beats with out_ready=1 → 8 consecutive out_valid cycles, in order, in_ready held at 1.
- Flush: with occupancy=2, assert flush together with in_valid → next cycle out_valid=0, occupancy=0, in_ready=1; the flushed beat never appears.
- Asynchronous reset mid-stall: with occupancy=2, pulse rst between clock edges → out_valid=0, out_data=0, in_ready=1 immediately.
